// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains an asynchronous_FIFO read port into a valid/ready stream with burst m_last.
// Ports:
//   clk, rst      read-domain clock, asynchronous active-low reset
//   empty, rdata  FIFO status and read data (rdata valid the cycle after r_en)
//   r_en          FIFO pop request
//   m_valid, m_ready, m_data, m_last   output stream; m_last marks every burst_len-th word
//   word_cnt      16-bit accepted-word counter, only when FIFO_READER_CNT_EN is defined
module fifo_stream_reader #(
    parameter int datasize  = 8,
    parameter int burst_len = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                empty,
    input  logic [datasize-1:0] rdata,
    output logic                r_en,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [datasize-1:0] m_data,
    output logic                m_last
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [15:0]         word_cnt
`endif
);
    localparam int BW = burst_len > 1 ? $clog2(burst_len) : 1;
    localparam logic [BW-1:0] LAST = BW'(burst_len - 1);
    logic [1:0]          occ_q, occ_d, occ_p, slots;
    logic                infl_q;
    logic [BW-1:0]       bcnt_q, bcnt_d;
    logic [datasize-1:0] b0_q, b0_d, b1_q, b1_d;
    logic                pop;
    assign pop     = m_valid & m_ready;
    assign slots   = occ_q + {1'b0, infl_q};
    // slots counts buffered plus in-flight words; a pop this cycle frees room for one more request
    assign r_en    = rst & !empty & ((slots < 2'd2) | ((slots == 2'd2) & pop));
    assign m_valid = (occ_q != 2'd0);
    assign m_data  = b0_q;
    assign m_last  = m_valid & (bcnt_q == LAST);
    always_comb begin
        occ_p  = occ_q - {1'b0, pop};
        b0_d   = pop ? b1_q : b0_q;
        b1_d   = b1_q;
        // the arriving word lands behind whatever survives this cycle's pop
        if (infl_q) begin
            if (occ_p == 2'd0) b0_d = rdata;
            else b1_d = rdata;
        end
        occ_d  = occ_p + {1'b0, infl_q};
        bcnt_d = pop ? ((bcnt_q == LAST) ? '0 : bcnt_q + 1'b1) : bcnt_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q  <= '0;
            infl_q <= 1'b0;
            bcnt_q <= '0;
            b0_q   <= '0;
            b1_q   <= '0;
        end else begin
            occ_q  <= occ_d;
            infl_q <= r_en;
            bcnt_q <= bcnt_d;
            b0_q   <= b0_d;
            b1_q   <= b1_d;
        end
    end
`ifdef FIFO_READER_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    assign cnt_d    = cnt_q + {15'd0, pop};
    assign word_cnt = cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`endif
endmodule
